// File: rtl/bcm_ram_scheduler.sv
// rtl/bcm_ram_scheduler.sv - RAM access scheduler: UART writes, row-pair plane reads, full clear
module bcm_ram_scheduler (
    input  logic        clk,
    input  logic        cleanReset_n,
    input  logic        rd_req,
    input  logic [4:0]  rd_row,
    input  logic        clr_req,
    input  logic        wr_valid,
    input  logic [6:0]  wr_addr,
    input  logic [63:0] wr_data,
    output logic        wr_ready,
    output logic        busy,
    output logic        rd_done,
    output logic        rd_err,
    output logic        clr_done,
    output logic [63:0] R1,
    output logic [63:0] R2,
    output logic [63:0] G1,
    output logic [63:0] G2,
    output logic [63:0] B1,
    output logic [63:0] B2,
    output logic        ram_we,
    output logic [6:0]  ram_addr,
    output logic [63:0] ram_din,
    input  logic [63:0] ram_dout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_CLEAR = 2'd2;

    logic [1:0]  r_state;
    logic [2:0]  r_cnt;
    logic [6:0]  r_base;
    logic [63:0] r_shadow [0:5];
    logic        w_row_ok;
    logic [6:0]  w_base;

    assign w_row_ok = (rd_row <= 5'd20);
    assign w_base   = {2'b00, rd_row} * 7'd6;
    assign busy     = (r_state != S_IDLE);
    assign wr_ready = (r_state == S_IDLE) & ~clr_req & ~rd_req;

    always_ff @(posedge clk or negedge cleanReset_n) begin
        if (!cleanReset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_base   <= '0;
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            rd_done  <= 1'b0;
            rd_err   <= 1'b0;
            clr_done <= 1'b0;
            R1       <= '0;
            R2       <= '0;
            G1       <= '0;
            G2       <= '0;
            B1       <= '0;
            B2       <= '0;
            for (int i = 0; i < 6; i++) r_shadow[i] <= '0;
        end else begin
            ram_we   <= 1'b0;
            rd_done  <= 1'b0;
            rd_err   <= 1'b0;
            clr_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clr_req) begin
                        r_state  <= S_CLEAR;
                        ram_we   <= 1'b1;
                        ram_addr <= '0;
                        ram_din  <= '0;
                    end else if (rd_req) begin
                        if (w_row_ok) begin
                            r_state  <= S_READ;
                            ram_addr <= w_base;
                            r_base   <= w_base;
                            r_cnt    <= '0;
                        end else begin
                            rd_err <= 1'b1;
                        end
                    end else if (wr_valid) begin
                        ram_we   <= 1'b1;
                        ram_addr <= wr_addr;
                        ram_din  <= wr_data;
                    end
                end
                S_READ: begin
                    // r_cnt counts cycles since the read started; data trails the address by one
                    if (r_cnt < 3'd5) ram_addr <= r_base + {4'b0000, r_cnt} + 7'd1;
                    if (r_cnt != 3'd0) r_shadow[r_cnt - 3'd1] <= ram_dout;
                    if (r_cnt == 3'd6) begin
                        R1      <= r_shadow[0];
                        R2      <= r_shadow[1];
                        G1      <= r_shadow[2];
                        G2      <= r_shadow[3];
                        B1      <= r_shadow[4];
                        B2      <= ram_dout;
                        rd_done <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    r_cnt <= r_cnt + 3'd1;
                end
                S_CLEAR: begin
                    ram_addr <= ram_addr + 7'd1;
                    if (ram_addr == 7'd127) begin
                        clr_done <= 1'b1;
                        r_state  <= S_IDLE;
                    end else begin
                        ram_we <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/bcm_ram_scheduler.md
BCM_RAM_SCHEDULER -- requirements
Module: bcm_ram_scheduler

Interface
REQ-001 SHALL: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL: cleanReset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL: rd_req  in  1  level request to fetch one row-pair of colour planes; sampled only in IDLE.
REQ-004 SHALL: rd_row  in  5  row-pair index; valid range 0..20.
REQ-005 SHALL: clr_req  in  1  level request to zero the whole RAM; sampled only in IDLE.
REQ-006 SHALL: wr_valid  in  1  UART-side write request.
REQ-007 SHALL: wr_addr  in  7  UART-side write address.
REQ-008 SHALL: wr_data  in  64  UART-side write data.
REQ-009 SHALL: wr_ready  out  1  write accepted when wr_valid and wr_ready are both high at a rising edge.
REQ-010 SHALL: busy  out  1  high when state is not IDLE.
REQ-011 SHALL: rd_done, rd_err, clr_done  out  1 each  single-cycle completion/error pulses.
REQ-012 SHALL: R1, R2, G1, G2, B1, B2  out  64 each  registered plane data for the display.
REQ-013 SHALL: ram_we  out  1, ram_addr  out  7, ram_din  out  64; all registered.
REQ-014 SHALL: ram_dout  in  64  RAM read data; valid the cycle after ram_addr is presented (1-cycle latency).

Function
REQ-015 SHALL: states IDLE, READ, CLEAR.
REQ-016 SHALL: IDLE priority: clr_req > rd_req > write.
REQ-017 SHALL: wr_ready = (state==IDLE) & !clr_req & !rd_req, combinational.
REQ-018 SHALL: accepted write at edge E drives ram_we=1, ram_addr=wr_addr, ram_din=wr_data in cycle E+1; back-to-back writes every cycle allowed.
REQ-019 SHALL: ram_we=0 in every cycle not carrying an accepted write or clear write.
REQ-020 SHALL: row base address = rd_row*6 (7-bit); word k (0..5) maps to R1, R2, G1, G2, B1, B2 in that order.
REQ-021 SHALL: rd_req with rd_row<=20 sampled at edge E -> READ; ram_addr=base+k in cycle E+1+k, k=0..5; ram_dout captured into shadow registers at edges E+2..E+7.
REQ-022 SHALL: at edge E+7, all six outputs update simultaneously from the shadow registers; rd_done high for cycle E+8; state returns to IDLE.
REQ-023 SHALL: R1..B2 hold their values at all other times; no partial update is ever visible.
REQ-024 SHALL: rd_req with rd_row>20 -> no RAM access, state stays IDLE, rd_err high for one cycle after the edge, outputs unchanged, rd_done not asserted.
REQ-025 SHALL: clr_req sampled at edge E -> CLEAR; ram_we=1, ram_din=0, ram_addr=0..127 in cycles E+1..E+128; clr_done high in cycle E+129; state returns to IDLE at edge E+128.
REQ-026 SHALL: clear leaves R1..B2 unchanged.
REQ-027 SHALL: rd_req, clr_req and wr_valid are ignored during READ/CLEAR (no queueing); wr_ready=0 there.
REQ-028 SHALL: after READ/CLEAR completes, a still-held request is re-sampled in the first IDLE cycle.
REQ-029 SHALL: ram_addr wraps 127->0 only at the end of CLEAR, with no extra write.

Reset
REQ-030 SHALL: cleanReset_n low -> state IDLE immediately; ram_we=0, ram_addr=0, ram_din=0; R1..B2=0; shadow registers=0; rd_done=rd_err=clr_done=0; busy=0.
REQ-031 SHALL: reset asserted mid-READ/CLEAR aborts the operation with no done pulse; outputs take reset values.
REQ-032 SHALL: first request is sampled at the first rising edge after cleanReset_n deasserts.

Verification
REQ-033 SHALL: write 0xA5..A5 to addr 6..11 via UART port, then rd_req rd_row=1 -> addr 6..11 issued in order, rd_done at E+8, all six planes = written data.
REQ-034 SHALL: rd_req and wr_valid high together in IDLE -> read wins, wr_ready=0; write is accepted in the first IDLE cycle after rd_done.
REQ-035 SHALL: rd_req rd_row=21 -> rd_err one pulse, ram_we=0, no address change, outputs unchanged.
REQ-036 SHALL: clr_req -> 128 consecutive zero writes to 0..127, clr_done once; a subsequent read of row 20 (addr 120..125) returns all zeros.
REQ-037 SHALL: cleanReset_n pulsed low at cycle E+4 of a READ -> ram_we=0 and outputs=0 immediately, no rd_done, busy=0.
REQ-038 SHALL: 10 back-to-back writes -> wr_ready stays high, 10 consecutive ram_we cycles with matching addr/data.
